// File: rtl/result_checker_pkg.sv
// Shared types and helpers for the result checker: FSM encoding, symbol defaults, saturating increment.
// Latency: n/a. Backpressure: n/a.
package result_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CHECK  = 2'b01,
        ST_REPORT = 2'b10
    } state_e;

    localparam logic [31:0] BEGIN_SYMBOL_DEF = 32'h0000_0168;
    localparam logic [31:0] END_SYMBOL_DEF   = 32'h0000_0D5D;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/result_checker_if.sv
// Snooped write bus, answer-table load port and checker status outputs.
// Latency: n/a. Backpressure: none, the checker is a passive observer.
interface result_checker_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4,
    parameter int ERR_W  = 8,
    parameter int DUR_W  = 16
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wen;
    logic              ans_we;
    logic [IDX_W-1:0]  ans_idx;
    logic [DATA_W-1:0] ans_data;
    logic [IDX_W:0]    check_num;
    logic [ERR_W-1:0]  error_num;
    logic [DUR_W-1:0]  duration;
    logic              finish;
    logic              timeout;
    logic [IDX_W:0]    checked;
    logic              first_err_valid;
    logic [IDX_W-1:0]  first_err_idx;
    logic [DATA_W-1:0] first_err_data;

    modport master (
        output addr, data, wen, ans_we, ans_idx, ans_data, check_num,
        input  error_num, duration, finish, timeout, checked,
               first_err_valid, first_err_idx, first_err_data
    );

    modport slave (
        input  addr, data, wen, ans_we, ans_idx, ans_data, check_num,
        output error_num, duration, finish, timeout, checked,
               first_err_valid, first_err_idx, first_err_data
    );
endinterface

// File: rtl/result_answer_ram.sv
// Expected-answer register file: one synchronous write port, one combinational read port.
// Latency: write visible next cycle, read same cycle. Backpressure: none.
module result_answer_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  widx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  ridx_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[widx_i] <= wdata_i;
    end

    assign rdata_o = mem_q[ridx_i];
endmodule

// File: rtl/result_checker.sv
// Snoops the data-memory write bus, checks results written to TEST_PORT against the answer table, then reports.
// Latency: status registered, finish combinational from state. Backpressure: none, the bus is never stalled.
module result_checker
    import result_checker_pkg::*;
#(
    parameter int                ADDR_W       = 30,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] TEST_PORT    = ADDR_W'('hFF),
    parameter logic [DATA_W-1:0] BEGIN_SYMBOL = DATA_W'(BEGIN_SYMBOL_DEF),
    parameter int                DEPTH        = 16,
    parameter int                IDX_W        = 4,
    parameter int                ERR_W        = 8,
    parameter int                DUR_W        = 16,
    parameter logic [DUR_W-1:0]  TIMEOUT      = '1
) (
    input logic            clk,
    input logic            rst,
    result_checker_if.slave bus
);
    localparam logic [IDX_W:0]   LIM_MAX = (IDX_W+1)'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic [ERR_W-1:0]  error_num_q, error_num_d;
    logic [DUR_W-1:0]  duration_q, duration_d;
    logic [IDX_W:0]    checked_q, checked_d;
    logic [IDX_W:0]    limit_q, limit_d;
    logic              timeout_q, timeout_d;
    logic              fe_valid_q, fe_valid_d;
    logic [IDX_W-1:0]  fe_idx_q, fe_idx_d;
    logic [DATA_W-1:0] fe_data_q, fe_data_d;
    logic              ram_we;
    logic [DATA_W-1:0] expected;
    logic              hit;
    logic [DUR_W-1:0]  dur_inc;
    logic [ERR_W-1:0]  err_inc;

    result_answer_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .widx_i  (bus.ans_idx),
        .wdata_i (bus.ans_data),
        .ridx_i  (checked_q[IDX_W-1:0]),
        .rdata_o (expected)
    );

    assign hit     = (bus.addr == TEST_PORT);
    assign dur_inc = DUR_W'(sat_inc(32'(duration_q), 32'(DUR_MAX)));
    assign err_inc = ERR_W'(sat_inc(32'(error_num_q), 32'(ERR_MAX)));

    always_comb begin
        state_d     = state_q;
        armed_d     = ~bus.wen;
        error_num_d = error_num_q;
        duration_d  = duration_q;
        checked_d   = checked_q;
        limit_d     = limit_q;
        timeout_d   = timeout_q;
        fe_valid_d  = fe_valid_q;
        fe_idx_d    = fe_idx_q;
        fe_data_d   = fe_data_q;
        ram_we      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ram_we = bus.ans_we;
                // Begin ignores the armed filter so a back-to-back begin write is never lost.
                if (bus.wen && hit && (bus.data == BEGIN_SYMBOL)) begin
                    error_num_d = '0;
                    duration_d  = '0;
                    checked_d   = '0;
                    limit_d     = (bus.check_num > LIM_MAX) ? LIM_MAX : bus.check_num;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (checked_q == limit_q) begin
                    duration_d = dur_inc;
                    state_d    = ST_REPORT;
                end else if (duration_q == TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_REPORT;
                end else begin
                    duration_d = dur_inc;
                    if (bus.wen && armed_q && hit) begin
                        checked_d = checked_q + 1'b1;
                        if (bus.data != expected) begin
                            error_num_d = err_inc;
                            if (!fe_valid_q) begin
                                fe_valid_d = 1'b1;
                                fe_idx_d   = checked_q[IDX_W-1:0];
                                fe_data_d  = bus.data;
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            error_num_q <= '1;
            duration_q  <= '0;
            checked_q   <= '0;
            limit_q     <= '0;
            timeout_q   <= 1'b0;
            fe_valid_q  <= 1'b0;
            fe_idx_q    <= '0;
            fe_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            error_num_q <= error_num_d;
            duration_q  <= duration_d;
            checked_q   <= checked_d;
            limit_q     <= limit_d;
            timeout_q   <= timeout_d;
            fe_valid_q  <= fe_valid_d;
            fe_idx_q    <= fe_idx_d;
            fe_data_q   <= fe_data_d;
        end
    end

    assign bus.finish          = (state_q == ST_REPORT);
    assign bus.error_num       = error_num_q;
    assign bus.duration        = duration_q;
    assign bus.timeout         = timeout_q;
    assign bus.checked         = checked_q;
    assign bus.first_err_valid = fe_valid_q;
    assign bus.first_err_idx   = fe_idx_q;
    assign bus.first_err_data  = fe_data_q;
endmodule
